// File: rtl/drum_pkg.sv
// rtl/drum_pkg.sv - shared defaults, types and helpers for the drum scheduler slice
package drum_pkg;

  localparam int DRUM_K    = 3;
  localparam int DRUM_N    = 8;
  localparam int DRUM_M    = 8;
  localparam int DRUM_NREQ = 4;

  typedef logic [$clog2(DRUM_NREQ)-1:0] drum_id_t;

  typedef struct packed {
    logic [DRUM_N+DRUM_M-1:0] data;
    drum_id_t                 id;
  } drum_res_t;

  // Round-robin successor of idx in a ring of nreq entries.
  function automatic int rr_next(input int idx, input int nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/drum.sv
// rtl/drum.sv - combinational DRUM approximate signed multiplier
//
// Ports:
//   a  in  N    : operand A, signed
//   b  in  M    : operand B, signed
//   r  out N+M  : approximate product
//
// Signs are handled in ones-complement: magnitudes are formed by bitwise
// inversion of negative operands and a negative product is the inverse of
// the unsigned product. Each magnitude keeps K bits starting at its leading
// one; when bits are dropped the kept LSB is forced to 1 to unbias the error.
module drum
  import drum_pkg::*;
#(
  parameter int K = DRUM_K,
  parameter int N = DRUM_N,
  parameter int M = DRUM_M
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] r
);

  logic           sgn;
  logic [N-1:0]   mag_a;
  logic [M-1:0]   mag_b;
  logic [K-1:0]   ta;
  logic [K-1:0]   tb;
  int             lead_a;
  int             lead_b;
  int             sh_a;
  int             sh_b;
  logic [N+M-1:0] prod;

  always_comb begin
    sgn   = a[N-1] ^ b[M-1];
    mag_a = a[N-1] ? ~a : a;
    mag_b = b[M-1] ? ~b : b;

    lead_a = 0;
    for (int i = 0; i < N; i++) begin
      if (mag_a[i]) lead_a = i;
    end
    lead_b = 0;
    for (int i = 0; i < M; i++) begin
      if (mag_b[i]) lead_b = i;
    end

    if (lead_a >= K) begin
      sh_a  = lead_a - K + 1;
      ta    = K'(mag_a >> sh_a);
      ta[0] = 1'b1;
    end else begin
      sh_a = 0;
      ta   = K'(mag_a);
    end

    if (lead_b >= K) begin
      sh_b  = lead_b - K + 1;
      tb    = K'(mag_b >> sh_b);
      tb[0] = 1'b1;
    end else begin
      sh_b = 0;
      tb   = K'(mag_b);
    end

    prod = ((N+M)'(ta) * (N+M)'(tb)) << (sh_a + sh_b);
    r    = sgn ? ~prod : prod;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req       in  NREQ : request vector
//   ptr       in  IDW  : index where the search starts (highest priority)
//   en        in  1    : grant enable; no grant when low
//   grant     out NREQ : one-hot-or-zero grant
//   grant_idx out IDW  : index of the granted request (0 when none)
module rr_arbiter
  import drum_pkg::*;
#(
  parameter int NREQ = DRUM_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drum_rr_sched.sv
// rtl/drum_rr_sched.sv - round-robin scheduler sharing one drum multiplier
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester operand handshake
//   req_a, req_b        : packed operands, slice i belongs to requester i
//   res_valid/res_ready : result handshake
//   res_data, res_id    : product and the requester that issued it
//   busy                : an operand or a result is held in the pipeline
//   op_count            : completed result handshakes, saturating
module drum_rr_sched
  import drum_pkg::*;
#(
  parameter int NREQ = DRUM_NREQ,
  parameter int K    = DRUM_K,
  parameter int N    = DRUM_N,
  parameter int M    = DRUM_M,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*M-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N+M-1:0]    res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy,
  output logic [15:0]       op_count
);

  logic            s1_valid;
  logic [N-1:0]    s1_a;
  logic [M-1:0]    s1_b;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  ptr;

  logic            s2_free;
  logic            s1_adv;
  logic            s1_free;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            accept;
  logic [N-1:0]    sel_a;
  logic [M-1:0]    sel_b;
  logic [N+M-1:0]  drum_r;

  // S1 can take a new operand when it is empty or drains into S2 this edge,
  // so a result handshake, an S1 advance and an accept can all coincide.
  assign s2_free = !res_valid || res_ready;
  assign s1_adv  = s1_valid && s2_free;
  assign s1_free = !s1_valid || s1_adv;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (s1_free),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_a     = req_a[int'(grant_idx)*N +: N];
  assign sel_b     = req_b[int'(grant_idx)*M +: M];

  drum #(
    .K (K),
    .N (N),
    .M (M)
  ) u_drum (
    .a (s1_a),
    .b (s1_b),
    .r (drum_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else begin
      if (accept) begin
        ptr      <= IDW'(rr_next(int'(grant_idx), NREQ));
        s1_valid <= 1'b1;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        s1_id    <= grant_idx;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      if (s1_adv) begin
        res_valid <= 1'b1;
        res_data  <= drum_r;
        res_id    <= s1_id;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (res_valid && res_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

  assign busy = s1_valid || res_valid;

endmodule

// File: doc/drum_rr_sched.md
# drum_rr_sched

Round-robin scheduler that shares one combinational `drum` approximate multiplier between `NREQ` requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one request per cycle, registers the operands, and runs them through the shared `drum` instance. It returns a registered 16-bit result tagged with the requester ID over a valid/ready result channel. It sits between the host-facing register file and the multiplier, replacing the fixed `ram[0]`/`ram[1]` operand wiring.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `K`, 3: drum truncation width, passed to `drum`.
- `N`, 8: operand A width.
- `M`, 8: operand B width.
- `IDW`, `$clog2(NREQ)`: requester ID width.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `req_valid` in NREQ: per-requester operand valid.
- `req_a` in NREQ*N: packed operand A; slice i belongs to requester i.
- `req_b` in NREQ*M: packed operand B.
- `req_ready` out NREQ: one-hot-or-zero grant/accept.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer ready.
- `res_data` out N+M: drum product.
- `res_id` out IDW: requester that issued the product.
- `busy` out 1: either pipeline stage holds data.
- `op_count` out 16: count of completed result handshakes, saturating at 16'hFFFF.

## Operation
- Two-stage pipeline.
  - S1: operand register holding `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - S2: result register holding `res_valid`, `res_data`, `res_id`.
  - `res_data` <= `drum(s1_a, s1_b)` with parameters `K`, `N`, `M`. The product is bit-identical to the existing `drum` module, including ones-complement sign handling.
- Advance rules:
  - `s2_free = !res_valid | res_ready`.
  - `s1_adv = s1_valid & s2_free`.
  - `s1_free = !s1_valid | s1_adv`.
- Arbitration:
  - Round-robin over `req_valid`, starting the search at pointer `ptr`.
  - A grant occurs only when `s1_free` is high.
  - `req_ready[i] = s1_free & grant[i]`.
  - At most one bit is set. `req_ready` may depend on `req_valid`.
- Pointer update:
  - On an accepted grant to i, `ptr <= (i+1) mod NREQ`.
  - Otherwise `ptr` holds.
  - Reset value of `ptr` is 0.
- A requester may drop `req_valid` without a handshake. The arbiter only samples the current cycle.
- `op_count` increments on `res_valid & res_ready` and saturates at 16'hFFFF.
- `busy = s1_valid | res_valid`.

## Timing
- Reset (async assert, sync release): `res_valid`=0, `res_data`=0, `res_id`=0, `req_ready`=0, `busy`=0, `op_count`=0, `s1_valid`=0, `ptr`=0.
  - Mid-operation reset discards both stages with no result emitted.
- Latency: request accepted at edge T gives `res_valid` high after edge T+1. That is 2 cycles from accept to visible result.
- Throughput: one result per cycle while `res_ready` is held high.
- Backpressure:
  - While `res_valid & !res_ready`, `res_data` and `res_id` are stable.
  - S1 holds its contents.
  - A new grant occurs only if S1 is empty; at most 2 items are in flight.
- Simultaneous events:
  - A result handshake and an S1 advance on the same edge refill S2 with no bubble.
  - Accept and S1 advance on the same edge is allowed.
- With all requesters valid continuously, the grant order is 0,1,2,3,0,... No requester waits more than NREQ-1 grants.

## Structure
- Package `drum_pkg` holds:
  - defaults `DRUM_K`, `DRUM_N`, `DRUM_M`, `DRUM_NREQ`;
  - typedef `drum_id_t`;
  - typedef `drum_res_t`, a struct of data and id.
- Sub-module `rr_arbiter`, parameter NREQ:
  - inputs: `req`, `ptr`, `en`;
  - outputs: one-hot `grant`, `grant_idx`.
  - It is combinational; the `ptr` register lives in the top module.
- `drum` is reused unchanged as a single instance.

## Test plan
- Reset mid-flight: assert `rst_n` low while both stages are full, then release. All outputs are 0 and no `res_valid` pulse appears.
- Single request: req 2 offers a=5, b=7 with `res_ready`=1. `req_ready[2]` is high that cycle; 2 cycles later `res_data`=35, `res_id`=2, and `op_count`=1 after the handshake.
- Approximation and sign:
  - a=100, b=3 gives 336.
  - a=8'hFB, b=7 gives 16'hFFE3.
- Fairness: all 4 requesters valid for 8 cycles with `res_ready`=1. `res_id` sequence is 0,1,2,3,0,1,2,3 and results arrive back-to-back with no bubbles.
- Backpressure: `res_ready`=0 for 5 cycles with requesters 0 and 1 valid.
  - Exactly 2 items are accepted and `res_data` stays stable.
  - `req_ready` stays 0 after that.
  - After `res_ready`=1, results appear in accept order with no loss.
- Saturation: preload or run 65 536 handshakes. `op_count` holds at 16'hFFFF.
